tdc_ctrl: RTL

// Power-up, injection and measurement sequencer for the TDC pair
// (tdc_analog + tdc_digital). It drives pd, pd_inj, en and ctr_freq in the

---
 rtl/tdc_ctrl_if.sv | 30 +++
 rtl/tdc_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/tdc_ctrl_if.sv
// Handshake and data bundle between the TDC sequencer and the ADPLL loop controller.
// The slave modport is the sequencer; the master modport is the loop controller side.
interface tdc_ctrl_if #(
  parameter int unsigned TDC_W = 12
);
  localparam int unsigned CF_W = 3;

  logic             start;
  logic             stop;
  logic [CF_W-1:0]  ctr_freq_in;
  logic [TDC_W-1:0] tdc_word;
  logic             pd;
  logic             pd_inj;
  logic             en;
  logic [CF_W-1:0]  ctr_freq;
  logic             busy;
  logic             ready;
  logic [TDC_W-1:0] avg_word;
  logic             avg_valid;

  modport master (
    output start, stop, ctr_freq_in, tdc_word,
    input  pd, pd_inj, en, ctr_freq, busy, ready, avg_word, avg_valid
  );

  modport slave (
    input  start, stop, ctr_freq_in, tdc_word,
    output pd, pd_inj, en, ctr_freq, busy, ready, avg_word, avg_valid
  );
endinterface

// File: rtl/tdc_ctrl.sv
// Power-up / injection / run sequencer for the TDC pair, with block averaging of
// tdc_word while in RUN. All outputs are registered.
module tdc_ctrl #(
  parameter int unsigned TDC_W      = 12,
  parameter int unsigned PU_CYCLES  = 32,
  parameter int unsigned INJ_CYCLES = 32,
  parameter int unsigned AVG_LOG2   = 3
) (
  input logic        clk,
  input logic        rst,
  tdc_ctrl_if.slave  bus
);

  localparam int unsigned MAX_DWELL = (PU_CYCLES > INJ_CYCLES) ? PU_CYCLES : INJ_CYCLES;
  localparam int unsigned CNT_W     = $clog2(MAX_DWELL + 1);
  localparam int unsigned ACC_W     = TDC_W + AVG_LOG2;
  localparam int unsigned CF_W      = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PWRUP = 2'd1,
    INJ   = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [AVG_LOG2-1:0]  r_smp;
  logic [ACC_W-1:0]     r_acc;
  logic                 r_pd;
  logic                 r_pd_inj;
  logic                 r_en;
  logic [CF_W-1:0]      r_ctr_freq;
  logic                 r_busy;
  logic                 r_ready;
  logic [TDC_W-1:0]     r_avg_word;
  logic                 r_avg_valid;

  logic [ACC_W-1:0]     w_sum;
  logic [TDC_W-1:0]     w_avg;
  logic                 w_last;

  // Running sum including the current sample; the block average is its upper TDC_W bits.
  assign w_sum  = r_acc + ACC_W'(bus.tdc_word);
  assign w_avg  = w_sum[ACC_W-1:AVG_LOG2];
  assign w_last = (r_smp == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_smp       <= '0;
      r_acc       <= '0;
      r_pd        <= 1'b1;
      r_pd_inj    <= 1'b1;
      r_en        <= 1'b0;
      r_ctr_freq  <= '0;
      r_busy      <= 1'b0;
      r_ready     <= 1'b0;
      r_avg_word  <= '0;
      r_avg_valid <= 1'b0;
    end else begin
      r_avg_valid <= 1'b0;
      // stop wins over start and over dwell expiry; avg_word and ctr_freq are kept
      if (bus.stop) begin
        r_state  <= IDLE;
        r_cnt    <= '0;
        r_smp    <= '0;
        r_acc    <= '0;
        r_pd     <= 1'b1;
        r_pd_inj <= 1'b1;
        r_en     <= 1'b0;
        r_busy   <= 1'b0;
        r_ready  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.start) begin
              r_state    <= PWRUP;
              r_cnt      <= CNT_W'(PU_CYCLES - 1);
              r_pd       <= 1'b0;
              r_busy     <= 1'b1;
              r_ctr_freq <= bus.ctr_freq_in;
            end
          end
          PWRUP: begin
            if (r_cnt == '0) begin
              r_state <= INJ;
              r_cnt   <= CNT_W'(INJ_CYCLES - 1);
              r_en    <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          INJ: begin
            if (r_cnt == '0) begin
              r_state  <= RUN;
              r_pd_inj <= 1'b0;
              r_ready  <= 1'b1;
              r_acc    <= '0;
              r_smp    <= '0;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          RUN: begin
            r_smp <= r_smp + 1'b1;
            if (w_last) begin
              r_avg_word  <= w_avg;
              r_avg_valid <= 1'b1;
              r_acc       <= '0;
            end else begin
              r_acc <= w_sum;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.pd        = r_pd;
  assign bus.pd_inj    = r_pd_inj;
  assign bus.en        = r_en;
  assign bus.ctr_freq  = r_ctr_freq;
  assign bus.busy      = r_busy;
  assign bus.ready     = r_ready;
  assign bus.avg_word  = r_avg_word;
  assign bus.avg_valid = r_avg_valid;

endmodule
